// File: rtl/mdr_ctrl.sv
// mdr_ctrl: sequencer for the multiply / divide / square-root datapath (operand mux select, load/shift enables).
// Latency: i_start to o_done is N+2 cycles (N = DW for mult/div, DW/2 for sqrt); one op every N+3 cycles.
// Backpressure: o_ready high only in IDLE; i_start outside IDLE is dropped, never queued.
//
// Ports: i_clk/i_rst_n (async active-low), i_start/i_op request, i_divisor_zero datapath flag (sampled in LOAD),
//        o_ready, o_sel (to operand mux i_sel), o_load, o_shift, o_iter (0-based index), o_done, o_error.
// Build option: define MDR_ERR_EN to add the ERR state (divide-by-zero and reserved opcode 11 report o_error);
//               without it, divide-by-zero runs normally, op 11 runs as mult and o_error is tied low.
module mdr_ctrl #(
    parameter int DW     = 16,
    parameter int DW_SEL = 3,
    localparam int CW    = $clog2(DW) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic              i_divisor_zero,
    output logic              o_ready,
    output logic [DW_SEL-1:0] o_sel,
    output logic              o_load,
    output logic              o_shift,
    output logic [CW-1:0]     o_iter,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;

    // Operand mux select codes
    localparam logic [DW_SEL-1:0] SEL_ZERO = DW_SEL'(0);
    localparam logic [DW_SEL-1:0] SEL_MULT = DW_SEL'(1);
    localparam logic [DW_SEL-1:0] SEL_DIV  = DW_SEL'(2);
    localparam logic [DW_SEL-1:0] SEL_SQRT = DW_SEL'(3);
    localparam logic [DW_SEL-1:0] SEL_RES  = DW_SEL'(4);

    // Index of the final CALC cycle for each iteration count
    localparam logic [CW-1:0] LAST_FULL = CW'(DW - 1);
    localparam logic [CW-1:0] LAST_HALF = CW'(DW / 2 - 1);

`ifdef MDR_ERR_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] last_iter;

    // sqrt needs half the iterations; every other opcode (including 11 when it runs) takes DW
    assign last_iter = (op_q == OP_SQRT) ? LAST_HALF : LAST_FULL;

`ifdef MDR_ERR_EN
    logic err_detect;
    // Only meaningful in LOAD, where the datapath presents a valid divisor-zero flag
    assign err_detect = ((op_q == OP_DIV) && i_divisor_zero) || (op_q == 2'b11);
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = i_divisor_zero;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef MDR_ERR_EN
                state_d = err_detect ? S_ERR : S_CALC;
`else
                state_d = S_CALC;
`endif
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
`ifdef MDR_ERR_EN
            S_ERR:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: decoded from state and counter only
    always_comb begin
        o_ready = 1'b0;
        o_sel   = SEL_ZERO;
        o_load  = 1'b0;
        o_shift = 1'b0;
        o_done  = 1'b0;
`ifdef MDR_ERR_EN
        o_error = 1'b0;
`endif
        case (state_q)
            S_IDLE: o_ready = 1'b1;
            S_LOAD: o_load  = 1'b1;
            S_CALC: begin
                o_shift = 1'b1;
                case (op_q)
                    OP_DIV:  o_sel = SEL_DIV;
                    OP_SQRT: o_sel = SEL_SQRT;
                    default: o_sel = SEL_MULT;
                endcase
            end
            S_DONE: begin
                o_done = 1'b1;
                o_sel  = SEL_RES;
            end
`ifdef MDR_ERR_EN
            S_ERR: begin
                o_done  = 1'b1;
                o_error = 1'b1;
                o_sel   = SEL_RES;
            end
`endif
            default: o_ready = 1'b0;
        endcase
    end

`ifndef MDR_ERR_EN
    assign o_error = 1'b0;
`endif

    assign o_iter = cnt_q;

endmodule

// File: tb/tb_mdr_ctrl.sv
// tb_mdr_ctrl: directed + randomized check of mdr_ctrl against a cycle-position reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mdr_ctrl;

    localparam int DW     = 16;
    localparam int DW_SEL = 3;
    localparam int CW     = $clog2(DW) + 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic [1:0]        i_op;
    logic              i_divisor_zero;
    logic              o_ready;
    logic [DW_SEL-1:0] o_sel;
    logic              o_load;
    logic              o_shift;
    logic [CW-1:0]     o_iter;
    logic              o_done;
    logic              o_error;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: an operation is described by its position (cycles since acceptance)
    bit       m_active = 1'b0;
    int       m_rel    = 0;
    bit [1:0] m_op     = 2'b00;
    bit       m_err    = 1'b0;

    mdr_ctrl #(.DW(DW), .DW_SEL(DW_SEL)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_op           (i_op),
        .i_divisor_zero (i_divisor_zero),
        .o_ready        (o_ready),
        .o_sel          (o_sel),
        .o_load         (o_load),
        .o_shift        (o_shift),
        .o_iter         (o_iter),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int iter_count(input bit [1:0] op);
        return (op == 2'b10) ? DW / 2 : DW;
    endfunction

    function automatic bit err_cond(input bit [1:0] op, input bit dz);
`ifdef MDR_ERR_EN
        return (op == 2'b11) || ((op == 2'b01) && dz);
`else
        return 1'b0;
`endif
    endfunction

    // Compare every output against what the model says this cycle should look like
    task automatic compare_outputs(input bit in_reset);
        int       n;
        bit       e_ready, e_load, e_shift, e_done, e_error, chk_iter;
        int       e_sel, e_iter;
        n = iter_count(m_op);
        e_ready = 0; e_load = 0; e_shift = 0; e_done = 0; e_error = 0;
        e_sel = 0; e_iter = 0; chk_iter = in_reset;
        if (!m_active) begin
            e_ready = 1;
        end else if (m_rel == 1) begin
            e_load = 1; chk_iter = 1; e_iter = 0;
        end else if (m_err && m_rel == 2) begin
            e_done = 1; e_error = 1; e_sel = 4;
        end else if (m_rel >= 2 && m_rel <= n + 1) begin
            e_shift = 1; chk_iter = 1; e_iter = m_rel - 2;
            e_sel = (m_op == 2'b01) ? 2 : (m_op == 2'b10) ? 3 : 1;
        end else begin
            e_done = 1; e_sel = 4;
        end
        check("ready", 32'(o_ready), 32'(e_ready));
        check("sel",   32'(o_sel),   32'(e_sel));
        check("load",  32'(o_load),  32'(e_load));
        check("shift", 32'(o_shift), 32'(e_shift));
        check("done",  32'(o_done),  32'(e_done));
        check("error", 32'(o_error), 32'(e_error));
        if (chk_iter) check("iter", 32'(o_iter), 32'(e_iter));
    endtask

    // Called at a falling edge: check this cycle, drive inputs for the next rising edge, advance the model
    task automatic step(input bit s, input bit [1:0] op, input bit dz);
        compare_outputs(1'b0);
        i_start = s;
        i_op = op;
        i_divisor_zero = dz;
        if (!m_active) begin
            if (s) begin
                m_active = 1; m_rel = 1; m_op = op; m_err = 0;
            end
        end else if (m_rel == 1) begin
            m_err = err_cond(m_op, dz);
            m_rel = 2;
        end else if (m_err && m_rel == 2) begin
            m_active = 0;
        end else if (m_rel == iter_count(m_op) + 2) begin
            m_active = 0;
        end else begin
            m_rel++;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 2'b00, 1'b0);
    endtask

    // Single-request run: start with op, dz held during the whole run, then idle until well past completion
    task automatic run_op(input bit [1:0] op, input bit dz);
        step(1'b1, op, dz);
        for (int i = 0; i < DW + 4; i++) step(1'b0, 2'b00, dz);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op = 2'b00;
        i_divisor_zero = 1'b0;
        #2;
        compare_outputs(1'b1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed: mult, sqrt, divide-by-zero, op 11, back-to-back with start held high
        run_op(2'b00, 1'b0);
        run_op(2'b10, 1'b0);
        run_op(2'b01, 1'b1);
        run_op(2'b01, 1'b0);
        run_op(2'b11, 1'b0);
        for (int i = 0; i < 2 * DW + 10; i++) step(1'b1, 2'b10, 1'b0);
        idle_steps(DW);

        // Busy start: sqrt request pulsed during a mult's CALC is ignored
        step(1'b1, 2'b00, 1'b0);
        idle_steps(6);
        step(1'b1, 2'b10, 1'b0);
        idle_steps(DW + 4);

        // Reset mid-CALC at iteration 5: outputs drop to reset values at once, no done afterwards
        step(1'b1, 2'b00, 1'b0);
        idle_steps(6);
        check("iter_before_rst", 32'(o_iter), 32'd5);
        i_rst_n = 1'b0;
        m_active = 0;
        m_op = 2'b00;
        #1;
        compare_outputs(1'b1);
        @(negedge i_clk);
        compare_outputs(1'b1);
        i_rst_n = 1'b1;
        idle_steps(3);
        run_op(2'b01, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        idle_steps(DW + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
